// File: rtl/fir_data_seq.sv
// fir_data_seq: clears a circular sample buffer, then for every accepted stream sample
// walks the data/tap BRAMs newest-to-oldest and presents NTAP operand pairs to a shared MAC.
module fir_data_seq #(
   parameter int NTAP = 11,
   parameter int AW   = 12,
   parameter int DW   = 32
) (
   input  logic          axis_clk,
   input  logic          axis_rst_n,
   input  logic          ap_start,
   input  logic [31:0]   data_length,
   input  logic          ss_tvalid,
   input  logic [DW-1:0] ss_tdata,
   output logic          ss_tready,
   output logic          data_EN,
   output logic [3:0]    data_WE,
   output logic [AW-1:0] data_A,
   output logic [DW-1:0] data_Di,
   input  logic [DW-1:0] data_Do,
   output logic          tap_EN,
   output logic [AW-1:0] tap_A,
   input  logic [DW-1:0] tap_Do,
   output logic          mac_valid,
   output logic [DW-1:0] mac_x,
   output logic [DW-1:0] mac_h,
   output logic          mac_first,
   output logic          mac_last,
   output logic          busy,
   output logic          ap_done
);
   localparam int KW  = (NTAP > 1) ? $clog2(NTAP) : 1;
   localparam int KW1 = KW + 1;
   localparam logic [KW-1:0] K_LAST = KW'(NTAP - 1);
   localparam logic [KW:0]   NTAP_W = KW1'(NTAP);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_WAIT_IN = 3'd2,
      S_READ    = 3'd3,
      S_DRAIN   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [KW-1:0] wp_q, wp_d;
   logic [31:0]   cnt_q, cnt_d;
   logic [31:0]   len_q, len_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          mv_q, mv_d;
   logic          mf_q, mf_d;
   logic          ml_q, ml_d;
   logic [KW:0]   wrap_sum_s;
   logic [KW-1:0] rd_word_s;

   function automatic logic [AW-1:0] word_addr(input logic [KW-1:0] w);
      return AW'({w, 2'b00});
   endfunction

   // (wp - k) mod NTAP: borrow case adds NTAP in one extra bit of headroom
   always_comb begin
      wrap_sum_s = {1'b0, wp_q} + NTAP_W - {1'b0, k_q};
      if (wp_q >= k_q) begin
         rd_word_s = wp_q - k_q;
      end else begin
         rd_word_s = wrap_sum_s[KW-1:0];
      end
   end

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      wp_d      = wp_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      mv_d      = 1'b0;
      mf_d      = 1'b0;
      ml_d      = 1'b0;
      ss_tready = 1'b0;
      data_EN   = 1'b0;
      data_WE   = 4'h0;
      data_A    = '0;
      data_Di   = '0;
      tap_EN    = 1'b0;
      tap_A     = '0;
      case (state_q)
         S_IDLE: begin
            if (ap_start) begin
               len_d   = data_length;
               cnt_d   = 32'd0;
               k_d     = '0;
               busy_d  = 1'b1;
               state_d = S_CLEAR;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CLEAR: begin
            data_EN = 1'b1;
            data_WE = 4'hF;
            data_A  = word_addr(k_q);
            if (k_q == K_LAST) begin
               k_d = '0;
               if (len_q == 32'd0) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_WAIT_IN;
               end
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         S_WAIT_IN: begin
            ss_tready = 1'b1;
            if (ss_tvalid) begin
               data_EN = 1'b1;
               data_WE = 4'hF;
               data_A  = word_addr(wp_q);
               data_Di = ss_tdata;
               k_d     = '0;
               state_d = S_READ;
            end else begin
               state_d = S_WAIT_IN;
            end
         end
         S_READ: begin
            data_EN = 1'b1;
            tap_EN  = 1'b1;
            data_A  = word_addr(rd_word_s);
            tap_A   = word_addr(k_q);
            mv_d    = 1'b1;
            mf_d    = (k_q == '0);
            ml_d    = (k_q == K_LAST);
            if (k_q == K_LAST) begin
               k_d     = '0;
               state_d = S_DRAIN;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         S_DRAIN: begin
            // the last operand pair is on the MAC port this cycle via mv_q
            wp_d  = (wp_q == K_LAST) ? '0 : wp_q + KW'(1);
            cnt_d = cnt_q + 32'd1;
            if ((cnt_q + 32'd1) < len_q) begin
               state_d = S_WAIT_IN;
            end else begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         wp_q    <= '0;
         cnt_q   <= 32'd0;
         len_q   <= 32'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mv_q    <= 1'b0;
         mf_q    <= 1'b0;
         ml_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         wp_q    <= wp_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         mv_q    <= mv_d;
         mf_q    <= mf_d;
         ml_q    <= ml_d;
      end
   end

   assign mac_valid = mv_q;
   assign mac_first = mf_q;
   assign mac_last  = ml_q;
   assign mac_x     = mv_q ? data_Do : '0;
   assign mac_h     = mv_q ? tap_Do : '0;
   assign busy      = busy_q;
   assign ap_done   = done_q;

endmodule

// File: tb/tb_fir_data_seq.sv
// tb_fir_data_seq: BRAM models plus a scoreboard of expected MAC operand pairs for fir_data_seq.
module tb_fir_data_seq;
   localparam int NTAP = 11;
   localparam int AW   = 12;
   localparam int DW   = 32;

   logic          axis_clk = 1'b0;
   logic          axis_rst_n = 1'b0;
   logic          ap_start = 1'b0;
   logic [31:0]   data_length = 32'd0;
   logic          ss_tvalid = 1'b0;
   logic [DW-1:0] ss_tdata = '0;
   logic          ss_tready;
   logic          data_EN;
   logic [3:0]    data_WE;
   logic [AW-1:0] data_A;
   logic [DW-1:0] data_Di;
   logic [DW-1:0] data_Do;
   logic          tap_EN;
   logic [AW-1:0] tap_A;
   logic [DW-1:0] tap_Do;
   logic          mac_valid;
   logic [DW-1:0] mac_x;
   logic [DW-1:0] mac_h;
   logic          mac_first;
   logic          mac_last;
   logic          busy;
   logic          ap_done;

   fir_data_seq #(.NTAP(NTAP), .AW(AW), .DW(DW)) dut (
      .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .ap_start(ap_start),
      .data_length(data_length), .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata),
      .ss_tready(ss_tready), .data_EN(data_EN), .data_WE(data_WE), .data_A(data_A),
      .data_Di(data_Di), .data_Do(data_Do), .tap_EN(tap_EN), .tap_A(tap_A),
      .tap_Do(tap_Do), .mac_valid(mac_valid), .mac_x(mac_x), .mac_h(mac_h),
      .mac_first(mac_first), .mac_last(mac_last), .busy(busy), .ap_done(ap_done)
   );

   always #5 axis_clk = ~axis_clk;

   typedef struct packed {
      logic [DW-1:0] x;
      logic [DW-1:0] h;
      logic          f;
      logic          l;
   } exp_t;

   logic [DW-1:0] dmem [0:1023];
   logic [AW-1:0] wr_a_q[$];
   logic [DW-1:0] wr_d_q[$];
   logic [AW-1:0] rd_a_q[$];
   exp_t          exp_q[$];
   logic [DW-1:0] sb [NTAP];
   int            hs_q[$];
   int            mwp = 0;
   int            n_cmp = 0;
   int            n_err = 0;
   int            viol = 0;
   int            mac_count = 0;
   int            cyc = 0;

   // data BRAM (garbage while in reset) and tap BRAM holding h[k] = k+1
   always @(posedge axis_clk) begin
      if (!axis_rst_n) begin
         for (int i = 0; i < 1024; i++) dmem[i] <= 32'hA5A5_0000 + 32'(i);
      end else if (data_EN) begin
         if (data_WE == 4'hF) begin
            dmem[data_A[AW-1:2]] <= data_Di;
            wr_a_q.push_back(data_A);
            wr_d_q.push_back(data_Di);
         end
         data_Do <= dmem[data_A[AW-1:2]];
      end
      if (tap_EN) begin
         tap_Do <= DW'(tap_A[AW-1:2]) + 32'd1;
         rd_a_q.push_back(data_A);
      end
   end

   task automatic tick();
      exp_t e;
      @(negedge axis_clk);
      cyc++;
      if (!mac_valid && (mac_first || mac_last)) viol++;
      if (!data_EN && data_WE != 4'h0) viol++;
      if (mac_valid && (ss_tready || data_WE != 4'h0 || !busy)) viol++;
      if (mac_valid) begin
         mac_count++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL mac_unexpected: got mac_x=%0d mac_h=%0d, expected no pulse", mac_x, mac_h);
         end else begin
            e = exp_q.pop_front();
            if ({mac_x, mac_h, mac_first, mac_last} !== {e.x, e.h, e.f, e.l}) begin
               n_err++;
               $display("FAIL mac_pair: got x=%0d h=%0d f=%0b l=%0b, expected x=%0d h=%0d f=%0b l=%0b",
                        mac_x, mac_h, mac_first, mac_last, e.x, e.h, e.f, e.l);
            end
         end
      end
   endtask

   task automatic model_accept(input logic [DW-1:0] x);
      exp_t e;
      sb[mwp] = x;
      for (int k = 0; k < NTAP; k++) begin
         e.x = sb[(mwp - k + NTAP) % NTAP];
         e.h = DW'(k + 1);
         e.f = (k == 0);
         e.l = (k == NTAP - 1);
         exp_q.push_back(e);
      end
      mwp = (mwp + 1) % NTAP;
      hs_q.push_back(cyc);
   endtask

   task automatic do_start(input logic [31:0] len);
      for (int i = 0; i < NTAP; i++) sb[i] = '0;
      ap_start = 1'b1;
      data_length = len;
      tick();
      ap_start = 1'b0;
   endtask

   task automatic send_sample(input logic [DW-1:0] x, input bit rnd, output bit ok);
      bit v;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         ss_tvalid = v;
         ss_tdata = v ? x : DW'($urandom);
         if (v && ss_tready) begin
            model_accept(x);
            ok = 1'b1;
         end
         tick();
      end
      ss_tvalid = 1'b0;
   endtask

   task automatic wait_done(output bit found);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick();
         if (ap_done) found = 1'b1;
      end
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (ss_tready) ok = 1'b1;
         else tick();
      end
   endtask

   task automatic do_reset();
      #2 axis_rst_n = 1'b0;
      exp_q.delete();
      mwp = 0;
      tick();
      axis_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      tick();
      tick();
      n_cmp++;
      if ({ss_tready, data_EN, data_WE, tap_EN, mac_valid, mac_first, mac_last, busy, ap_done} !== '0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b, expected all zero",
                  {ss_tready, data_EN, data_WE, tap_EN, mac_valid, mac_first, mac_last, busy, ap_done});
      end
      n_cmp++;
      if ({data_A, tap_A, data_Di, mac_x, mac_h} !== '0) begin
         n_err++;
         $display("FAIL reset_data: got A=%h tA=%h Di=%h x=%h h=%h, expected zero", data_A, tap_A, data_Di, mac_x, mac_h);
      end
      axis_rst_n = 1'b1;
      tick();
      n_cmp++;
      if ({busy, ss_tready} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_idle: got busy/tready=%b, expected 00", {busy, ss_tready});
      end
   endtask

   task automatic test_clear();
      wr_a_q.delete();
      wr_d_q.delete();
      do_start(32'd1);
      repeat (NTAP - 1) tick();
      n_cmp++;
      if (ss_tready !== 1'b0) begin
         n_err++;
         $display("FAIL clear_len: got ss_tready=%b during last clear cycle, expected 0", ss_tready);
      end
      tick();
      n_cmp++;
      if ({ss_tready, busy} !== 2'b11) begin
         n_err++;
         $display("FAIL clear_ready: got tready/busy=%b, expected 11", {ss_tready, busy});
      end
      #1;
      n_cmp++;
      if (wr_a_q.size() != NTAP) begin
         n_err++;
         $display("FAIL clear_count: got %0d writes, expected %0d", wr_a_q.size(), NTAP);
      end else begin
         for (int i = 0; i < NTAP; i++) begin
            n_cmp++;
            if (wr_a_q[i] !== AW'(i * 4) || wr_d_q[i] !== '0) begin
               n_err++;
               $display("FAIL clear_write: got A=%h D=%h, expected A=%h D=0", wr_a_q[i], wr_d_q[i], i * 4);
            end
         end
      end
   endtask

   task automatic test_single();
      bit ok, found;
      int m0;
      m0 = mac_count;
      send_sample(32'd5, 1'b0, ok);
      wait_done(found);
      n_cmp++;
      if (!ok || !found || busy !== 1'b0) begin
         n_err++;
         $display("FAIL single_done: got accepted=%0b done=%0b busy=%b, expected 1 1 0", ok, found, busy);
      end
      n_cmp++;
      if (mac_count - m0 != NTAP || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL single_pulses: got %0d pulses (%0d pending), expected %0d", mac_count - m0, exp_q.size(), NTAP);
      end
   endtask

   task automatic test_back_to_back();
      bit ok, found;
      int oks;
      oks = 0;
      hs_q.delete();
      do_start(32'd3);
      for (int s = 0; s < 3; s++) begin
         send_sample(DW'(100 * (s + 1)), 1'b0, ok);
         if (ok) oks++;
      end
      wait_done(found);
      n_cmp++;
      if (oks != 3 || !found) begin
         n_err++;
         $display("FAIL b2b_done: got accepted=%0d done=%0b, expected 3 1", oks, found);
      end else begin
         for (int i = 1; i < 3; i++) begin
            n_cmp++;
            if (hs_q[i] - hs_q[i-1] != 13) begin
               n_err++;
               $display("FAIL b2b_period: got %0d cycles between samples, expected 13", hs_q[i] - hs_q[i-1]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok, found;
      int oks, m0;
      oks = 0;
      viol = 0;
      m0 = mac_count;
      do_start(32'd5);
      for (int s = 0; s < 5; s++) begin
         send_sample(DW'($urandom_range(1, 1000)), 1'b1, ok);
         if (ok) oks++;
      end
      wait_done(found);
      n_cmp++;
      if (oks != 5 || !found || mac_count - m0 != 55) begin
         n_err++;
         $display("FAIL bp_count: got accepted=%0d done=%0b pulses=%0d, expected 5 1 55", oks, found, mac_count - m0);
      end
      n_cmp++;
      if (viol != 0) begin
         n_err++;
         $display("FAIL bp_protocol: got %0d protocol violations, expected 0", viol);
      end
   endtask

   task automatic test_corner();
      bit ok1, ok2, found;
      int m0;
      m0 = mac_count;
      do_start(32'd0);
      repeat (NTAP - 1) tick();
      n_cmp++;
      if (ap_done !== 1'b0) begin
         n_err++;
         $display("FAIL zero_early: got ap_done=%b during clear, expected 0", ap_done);
      end
      tick();
      n_cmp++;
      if ({ap_done, busy} !== 2'b10) begin
         n_err++;
         $display("FAIL zero_done: got done/busy=%b after clear, expected 10", {ap_done, busy});
      end
      tick();
      n_cmp++;
      if (ap_done !== 1'b0 || mac_count != m0) begin
         n_err++;
         $display("FAIL zero_pulse: got ap_done=%b pulses=%0d, expected 0 0", ap_done, mac_count - m0);
      end
      m0 = mac_count;
      do_start(32'd2);
      send_sample(32'd7, 1'b0, ok1);
      repeat (3) tick();
      ap_start = 1'b1;
      data_length = 32'd40;
      tick();
      ap_start = 1'b0;
      data_length = 32'd0;
      n_cmp++;
      if (busy !== 1'b1 || ss_tready !== 1'b0) begin
         n_err++;
         $display("FAIL start_in_read: got busy/tready=%b, expected 10", {busy, ss_tready});
      end
      send_sample(32'd8, 1'b0, ok2);
      wait_done(found);
      n_cmp++;
      if (!ok1 || !ok2 || !found || mac_count - m0 != 2 * NTAP) begin
         n_err++;
         $display("FAIL start_ignored: got done=%0b pulses=%0d, expected 1 %0d", found, mac_count - m0, 2 * NTAP);
      end
   endtask

   task automatic test_wrap();
      bit ok, found;
      int oks;
      logic [AW-1:0] ea;
      oks = 0;
      do_reset();
      do_start(32'd13);
      for (int s = 1; s <= 13; s++) begin
         if (s == 13) begin
            wait_ready(ok);
            wr_a_q.delete();
            rd_a_q.delete();
         end
         send_sample(DW'(s), 1'b0, ok);
         if (ok) oks++;
      end
      wait_done(found);
      n_cmp++;
      if (oks != 13 || !found || wr_a_q.size() != 1 || wr_a_q[0] !== 12'h004) begin
         n_err++;
         $display("FAIL wrap_write: got accepted=%0d done=%0b writes=%0d, expected 13 1 1 at 0x004", oks, found, wr_a_q.size());
      end
      n_cmp++;
      if (rd_a_q.size() != NTAP) begin
         n_err++;
         $display("FAIL wrap_reads: got %0d reads, expected %0d", rd_a_q.size(), NTAP);
      end else begin
         for (int k = 0; k < NTAP; k++) begin
            ea = (k == 0) ? 12'h004 : (k == 1) ? 12'h000 : AW'(40 - (k - 2) * 4);
            n_cmp++;
            if (rd_a_q[k] !== ea) begin
               n_err++;
               $display("FAIL wrap_addr: got data_A=%h at k=%0d, expected %h", rd_a_q[k], k, ea);
            end
         end
      end
   endtask

   task automatic test_reset_mid_read();
      bit ok, found, act;
      int m0;
      do_start(32'd3);
      send_sample(32'd9, 1'b0, ok);
      repeat (6) tick();
      #2 axis_rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({ss_tready, data_EN, data_WE, tap_EN, mac_valid, mac_first, mac_last, busy, ap_done} !== '0 ||
          {data_A, tap_A, mac_x, mac_h} !== '0) begin
         n_err++;
         $display("FAIL rst_read: got ctrl=%b A=%h x=%h, expected all zero",
                  {ss_tready, data_EN, data_WE, tap_EN, mac_valid, mac_first, mac_last, busy, ap_done}, data_A, mac_x);
      end
      exp_q.delete();
      mwp = 0;
      tick();
      axis_rst_n = 1'b1;
      act = 1'b0;
      repeat (3) begin
         tick();
         if (data_EN || tap_EN || ap_done || busy || mac_valid) act = 1'b1;
      end
      n_cmp++;
      if (act) begin
         n_err++;
         $display("FAIL rst_quiet: got activity after reset abort, expected none");
      end
      m0 = mac_count;
      do_start(32'd1);
      send_sample(32'd21, 1'b0, ok);
      wait_done(found);
      n_cmp++;
      if (!ok || !found || mac_count - m0 != NTAP || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL rst_restart: got done=%0b pulses=%0d, expected 1 %0d", found, mac_count - m0, NTAP);
      end
   endtask

   initial begin
      test_reset();
      test_clear();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_corner();
      test_wrap();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
